// File: rtl/mm_sched_pkg.sv
// ----------------------------------------------------------------------------
// mm_sched_pkg
// Shared types for the matrix-multiply job scheduler:
//   sched_state_e : scheduler FSM states (IDLE, RUN, RELEASE, REPORT)
//   job_t         : one queued job descriptor (packed config + tag)
// The record widths below define what the job FIFO stores. The scheduler's
// CFG_W / ID_W parameters default to these widths and must track them.
// ----------------------------------------------------------------------------
package mm_sched_pkg;

    localparam int JOB_CFG_W = 64;
    localparam int JOB_ID_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2,
        REPORT  = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic [JOB_CFG_W-1:0] cfg;
        logic [JOB_ID_W-1:0]  id;
    } job_t;

endpackage

// File: rtl/mm_job_fifo.sv
// ----------------------------------------------------------------------------
// mm_job_fifo
// Small circular FIFO of job descriptors with occupancy reporting.
// Ports:
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   push_i        : write request; ignored while full (no bypass on pop)
//   data_i        : job written on an accepted push
//   pop_i         : read request; ignored while empty
//   data_o        : job at the head of the queue
//   full_o        : occupancy == DEPTH
//   empty_o       : occupancy == 0
//   count_o       : current occupancy
// ----------------------------------------------------------------------------
module mm_job_fifo
    import mm_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  job_t                     data_i,
    input  logic                     pop_i,
    output job_t                     data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

    job_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Fullness is judged on the registered count, so a pop in the same cycle
    // never frees a slot for a push that arrives while full.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Reset empties the queue by clearing pointers and count; stale storage
    // contents are unreachable afterwards.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mm_job_scheduler.sv
// ----------------------------------------------------------------------------
// mm_job_scheduler
// Queues matrix-multiply jobs and runs them on the multiplier one at a time
// through a level start/done handshake, then reports a tagged completion.
// Ports:
//   clk_i, rstn_i   : clock, asynchronous active-low reset
//   job_valid_i     : job offered; accepted when job_ready_o is high
//   job_ready_o     : job queue not full
//   job_cfg_i       : packed multiplier config for the offered job
//   job_id_i        : tag for the offered job
//   timeout_i       : max cycles a job may stay running; 0 disables timeout
//   ext_en_i        : multiplier in external mode; holds off new launches
//   mm_start_o      : multiplier start level
//   mm_cfg_o        : config of the current/last launched job
//   mm_done_i       : multiplier done level
//   cmp_valid_o     : completion record available
//   cmp_ready_i     : completion record accepted
//   cmp_id_o        : tag of the completed job
//   cmp_timeout_o   : job ended by timeout rather than done
//   busy_o          : a job is in flight (launch through completion accept)
//   q_count_o       : queued jobs not yet launched
// ----------------------------------------------------------------------------
module mm_job_scheduler
    import mm_sched_pkg::*;
#(
    parameter int CFG_W = JOB_CFG_W,
    parameter int ID_W  = JOB_ID_W,
    parameter int DEPTH = 4,
    parameter int TO_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    job_valid_i,
    output logic                    job_ready_o,
    input  logic [CFG_W-1:0]        job_cfg_i,
    input  logic [ID_W-1:0]         job_id_i,
    input  logic [TO_W-1:0]         timeout_i,
    input  logic                    ext_en_i,
    output logic                    mm_start_o,
    output logic [CFG_W-1:0]        mm_cfg_o,
    input  logic                    mm_done_i,
    output logic                    cmp_valid_o,
    input  logic                    cmp_ready_i,
    output logic [ID_W-1:0]         cmp_id_o,
    output logic                    cmp_timeout_o,
    output logic                    busy_o,
    output logic [$clog2(DEPTH):0]  q_count_o
);

    sched_state_e      state_q;
    logic              start_q;
    logic [CFG_W-1:0]  cfg_q;
    logic [ID_W-1:0]   id_q;
    logic              to_flag_q;
    logic              cmp_valid_q;
    logic [TO_W-1:0]   tcnt_q;

    job_t              push_job;
    job_t              head_job;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              timeout_hit;

    assign push_job.cfg = job_cfg_i;
    assign push_job.id  = job_id_i;

    mm_job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (job_valid_i),
        .data_i  (push_job),
        .pop_i   (pop),
        .data_o  (head_job),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (q_count_o)
    );

    // A launch only happens from IDLE; external mode just withholds it.
    assign pop = (state_q == IDLE) && !fifo_empty && !ext_en_i;

    // The counter starts at 0 on the first RUN cycle, so the job is cut off
    // after exactly timeout_i cycles of start being high.
    assign timeout_hit = (timeout_i != '0) && (tcnt_q == (timeout_i - TO_W'(1)));

    // Job sequencing FSM; all multiplier and completion outputs are registered
    // here so they change only on clock edges (or drop at once on reset).
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            cfg_q       <= '0;
            id_q        <= '0;
            to_flag_q   <= 1'b0;
            cmp_valid_q <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        cfg_q   <= head_job.cfg;
                        id_q    <= head_job.id;
                        tcnt_q  <= '0;
                        start_q <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Done takes priority over a timeout landing in the same cycle.
                    if (mm_done_i) begin
                        start_q   <= 1'b0;
                        to_flag_q <= 1'b0;
                        state_q   <= RELEASE;
                    end else if (timeout_hit) begin
                        start_q   <= 1'b0;
                        to_flag_q <= 1'b1;
                        state_q   <= RELEASE;
                    end else begin
                        tcnt_q <= tcnt_q + TO_W'(1);
                    end
                end
                RELEASE: begin
                    // Wait for the multiplier to drop done so the next start is
                    // seen as a fresh request.
                    if (!mm_done_i) begin
                        cmp_valid_q <= 1'b1;
                        state_q     <= REPORT;
                    end
                end
                REPORT: begin
                    if (cmp_ready_i) begin
                        cmp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign job_ready_o   = !fifo_full;
    assign mm_start_o    = start_q;
    assign mm_cfg_o      = cfg_q;
    assign cmp_valid_o   = cmp_valid_q;
    assign cmp_id_o      = id_q;
    assign cmp_timeout_o = to_flag_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_mm_job_scheduler.sv
// ----------------------------------------------------------------------------
// tb_mm_job_scheduler
// Self-checking bench for mm_job_scheduler. Stimulus offers jobs, each
// carrying the latency the multiplier model will answer with; a monitor keeps
// a job-queue model and an expected-completion scoreboard, and a responder
// plays the multiplier's done behaviour.
// ----------------------------------------------------------------------------
module tb_mm_job_scheduler;

    localparam int CFG_W = 64;
    localparam int ID_W  = 4;
    localparam int DEPTH = 4;
    localparam int TO_W  = 16;

    logic               clk = 1'b0;
    logic               rstn_i = 1'b0;
    logic               job_valid_i = 1'b0;
    logic               job_ready_o;
    logic [CFG_W-1:0]   job_cfg_i = '0;
    logic [ID_W-1:0]    job_id_i = '0;
    logic [TO_W-1:0]    timeout_i = '0;
    logic               ext_en_i = 1'b0;
    logic               mm_start_o;
    logic [CFG_W-1:0]   mm_cfg_o;
    logic               mm_done_i = 1'b0;
    logic               cmp_valid_o;
    logic               cmp_ready_i = 1'b1;
    logic [ID_W-1:0]    cmp_id_o;
    logic               cmp_timeout_o;
    logic               busy_o;
    logic [$clog2(DEPTH):0] q_count_o;

    mm_job_scheduler #(
        .CFG_W (CFG_W),
        .ID_W  (ID_W),
        .DEPTH (DEPTH),
        .TO_W  (TO_W)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn_i),
        .job_valid_i   (job_valid_i),
        .job_ready_o   (job_ready_o),
        .job_cfg_i     (job_cfg_i),
        .job_id_i      (job_id_i),
        .timeout_i     (timeout_i),
        .ext_en_i      (ext_en_i),
        .mm_start_o    (mm_start_o),
        .mm_cfg_o      (mm_cfg_o),
        .mm_done_i     (mm_done_i),
        .cmp_valid_o   (cmp_valid_o),
        .cmp_ready_i   (cmp_ready_i),
        .cmp_id_o      (cmp_id_o),
        .cmp_timeout_o (cmp_timeout_o),
        .busy_o        (busy_o),
        .q_count_o     (q_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [CFG_W-1:0] cfg;
        int               k;
        int               h;
    } jobRec_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic            to;
    } cmpRec_t;

    jobRec_t modelQ[$];
    cmpRec_t expQ[$];

    int   total = 0;
    int   bad   = 0;

    // Monitor/model state
    logic pushAccepted = 1'b0;
    logic modelBusy    = 1'b0;
    logic startPrev    = 1'b0;
    logic validPrev    = 1'b0;
    logic [ID_W-1:0] idPrev = '0;
    logic toPrev       = 1'b0;
    int   curK = 0;
    int   curH = 1;
    int   curExpHigh = 0;
    int   highCnt = 0;
    int   sizeBefore = 0;
    logic idleBefore = 1'b0;
    logic startRose  = 1'b0;
    logic startFell  = 1'b0;
    jobRec_t mj;
    cmpRec_t me;
    logic expTo = 1'b0;

    // Stimulus-side job attributes travelling with the offered job
    int   stimK = 1;
    int   stimH = 1;
    logic readyRandom = 1'b0;
    logic readyForce  = 1'b1;

    // Responder state
    logic rspActive = 1'b0;
    int   rspCnt = 0;
    int   rspK = 0;
    int   rspHold = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Offer one job until the model says it was accepted; a long stall while
    // external mode holds the queue releases external mode.
    task automatic applyStimulus(input logic [ID_W-1:0] id, input logic [CFG_W-1:0] cfg,
                                 input int k, input int h);
        int waited = 0;
        job_valid_i = 1'b1;
        job_id_i    = id;
        job_cfg_i   = cfg;
        stimK       = k;
        stimH       = h;
        do begin
            tick();
            waited++;
            if (waited == 20) ext_en_i = 1'b0;
        end while (!pushAccepted && waited < 2000);
        job_valid_i = 1'b0;
        checkOutput("push_accepted", 64'(pushAccepted), 64'd1);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((modelQ.size() != 0 || expQ.size() != 0 || modelBusy) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_in_budget", 64'(n < budget), 64'd1);
    endtask

    task automatic waitStart(input int budget);
        int n = 0;
        while (!mm_start_o && n < budget) begin
            tick();
            n++;
        end
        checkOutput("start_seen", 64'(mm_start_o), 64'd1);
    endtask

    // Completion-ready driver
    always begin
        @(negedge clk);
        #1;
        if (readyRandom) cmp_ready_i = ($urandom_range(0, 1) == 1);
        else             cmp_ready_i = readyForce;
    end

    // Multiplier model: raises done on the k-th cycle start is seen high
    // (k==0 means never) and holds it for h cycles.
    always begin
        @(negedge clk);
        #2;
        if (!rstn_i) begin
            mm_done_i = 1'b0;
            rspActive = 1'b0;
            rspCnt    = 0;
        end else if (mm_start_o) begin
            if (!rspActive) begin
                rspActive = 1'b1;
                rspCnt    = 0;
                rspK      = curK;
            end
            rspCnt++;
            if (rspK != 0 && rspCnt == rspK) begin
                mm_done_i = 1'b1;
                rspHold   = curH - 1;
            end
        end else if (mm_done_i) begin
            if (rspHold <= 0) mm_done_i = 1'b0;
            else              rspHold--;
        end else begin
            rspActive = 1'b0;
        end
    end

    // Monitor and scoreboard: at each falling edge, account for what happened
    // at the preceding rising edge using inputs that were stable across it.
    always @(negedge clk) begin
        if (!rstn_i) begin
            modelQ.delete();
            expQ.delete();
            modelBusy    = 1'b0;
            startPrev    = 1'b0;
            validPrev    = 1'b0;
            pushAccepted = 1'b0;
            highCnt      = 0;
            curExpHigh   = 0;
        end else begin
            sizeBefore = modelQ.size();
            idleBefore = !modelBusy;
            startRose  = mm_start_o && !startPrev;
            startFell  = !mm_start_o && startPrev;

            if (idleBefore)
                checkOutput("launch", 64'(startRose), 64'(sizeBefore > 0 && !ext_en_i));
            else
                checkOutput("launch_while_busy", 64'(startRose), 64'd0);

            if (startRose && sizeBefore > 0) begin
                mj = modelQ.pop_front();
                checkOutput("mm_cfg", mm_cfg_o, mj.cfg);
                expTo = (timeout_i != 0) && (mj.k == 0 || mj.k > int'(timeout_i));
                me.id = mj.id;
                me.to = expTo;
                expQ.push_back(me);
                modelBusy  = 1'b1;
                curK       = mj.k;
                curH       = mj.h;
                curExpHigh = expTo ? int'(timeout_i) : mj.k;
                highCnt    = 0;
            end

            if (mm_start_o) highCnt++;
            if (startFell && curExpHigh > 0)
                checkOutput("start_high_cycles", 64'(highCnt), 64'(curExpHigh));

            pushAccepted = job_valid_i && (sizeBefore < DEPTH);
            if (pushAccepted)
                modelQ.push_back('{id: job_id_i, cfg: job_cfg_i, k: stimK, h: stimH});

            if (validPrev && cmp_ready_i) begin
                checkOutput("cmp_pending", 64'(expQ.size() != 0), 64'd1);
                if (expQ.size() != 0) begin
                    me = expQ.pop_front();
                    checkOutput("cmp_id", 64'(idPrev), 64'(me.id));
                    checkOutput("cmp_timeout", 64'(toPrev), 64'(me.to));
                end
                modelBusy = 1'b0;
            end else if (validPrev) begin
                checkOutput("cmp_hold_valid", 64'(cmp_valid_o), 64'd1);
                checkOutput("cmp_hold_id", 64'(cmp_id_o), 64'(idPrev));
                checkOutput("cmp_hold_to", 64'(cmp_timeout_o), 64'(toPrev));
            end

            if (cmp_valid_o && !validPrev) begin
                checkOutput("report_done_low", 64'(mm_done_i), 64'd0);
                checkOutput("report_start_low", 64'(mm_start_o), 64'd0);
            end

            checkOutput("q_count", 64'(q_count_o), 64'(modelQ.size()));
            checkOutput("job_ready", 64'(job_ready_o), 64'(modelQ.size() < DEPTH));
            checkOutput("busy", 64'(busy_o), 64'(modelBusy));

            startPrev = mm_start_o;
            validPrev = cmp_valid_o;
            idPrev    = cmp_id_o;
            toPrev    = cmp_timeout_o;
        end
    end

    // Main stimulus sequence
    initial begin
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_start", 64'(mm_start_o), 64'd0);
        checkOutput("rst_cmp_valid", 64'(cmp_valid_o), 64'd0);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_q_count", 64'(q_count_o), 64'd0);
        checkOutput("rst_ready", 64'(job_ready_o), 64'd1);
        checkOutput("rst_cfg", mm_cfg_o, 64'd0);
        checkOutput("rst_cmp_id", 64'(cmp_id_o), 64'd0);
        rstn_i = 1'b1;
        tick();

        // Single job, done after 10 cycles, no timeout
        timeout_i = 16'd0;
        applyStimulus(4'd3, 64'h0123_4567_89ab_cdef, 10, 1);
        tick();
        checkOutput("first_launch", 64'(mm_start_o), 64'd1);
        waitDrain(200);

        // Fill the queue while external mode holds launches off
        timeout_i = 16'd20;
        ext_en_i  = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus(4'(i), {$urandom, $urandom}, $urandom_range(1, 6), 1);
        checkOutput("fill_q_count", 64'(q_count_o), 64'd4);
        checkOutput("fill_ready", 64'(job_ready_o), 64'd0);
        job_valid_i = 1'b1;
        job_id_i    = 4'd5;
        job_cfg_i   = 64'hdead_beef_0000_0005;
        stimK       = 1;
        repeat (2) tick();
        job_valid_i = 1'b0;
        checkOutput("full_push_ignored", 64'(q_count_o), 64'd4);
        ext_en_i = 1'b0;
        waitDrain(400);

        // Timeout behaviour
        timeout_i = 16'd5;
        applyStimulus(4'd7, {$urandom, $urandom}, 0, 1);
        waitDrain(200);
        applyStimulus(4'd8, {$urandom, $urandom}, 5, 3);
        waitDrain(200);
        applyStimulus(4'd9, {$urandom, $urandom}, 6, 1);
        waitDrain(200);
        timeout_i = 16'd0;
        applyStimulus(4'd10, {$urandom, $urandom}, 300, 2);
        waitStart(10);
        repeat (200) tick();
        checkOutput("no_timeout_still_running", 64'(mm_start_o), 64'd1);
        waitDrain(400);

        // External mode blocks launch; completion record held without ready
        readyForce = 1'b0;
        ext_en_i   = 1'b1;
        applyStimulus(4'd11, {$urandom, $urandom}, 3, 1);
        repeat (10) tick();
        checkOutput("ext_blocks_start", 64'(mm_start_o), 64'd0);
        ext_en_i = 1'b0;
        tick();
        checkOutput("ext_release_launch", 64'(mm_start_o), 64'd1);
        repeat (15) tick();
        checkOutput("cmp_held_valid", 64'(cmp_valid_o), 64'd1);
        checkOutput("cmp_held_id", 64'(cmp_id_o), 64'd11);
        readyForce = 1'b1;
        waitDrain(100);

        // Randomized batches
        readyRandom = 1'b1;
        for (int b = 0; b < 3; b++) begin
            timeout_i = 16'($urandom_range(3, 10));
            for (int i = 0; i < 15; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                ext_en_i = ($urandom_range(0, 3) == 0);
                applyStimulus(4'($urandom_range(0, 15)), {$urandom, $urandom},
                              ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12),
                              $urandom_range(1, 3));
            end
            ext_en_i = 1'b0;
            waitDrain(3000);
        end
        readyRandom = 1'b0;
        readyForce  = 1'b1;

        // Asynchronous reset in the middle of a job with two queued behind it
        timeout_i = 16'd0;
        applyStimulus(4'd12, {$urandom, $urandom}, 0, 1);
        waitStart(10);
        applyStimulus(4'd13, {$urandom, $urandom}, 2, 1);
        applyStimulus(4'd14, {$urandom, $urandom}, 2, 1);
        checkOutput("pre_rst_q_count", 64'(q_count_o), 64'd2);
        checkOutput("pre_rst_start", 64'(mm_start_o), 64'd1);
        rstn_i = 1'b0;
        #1;
        checkOutput("async_rst_start", 64'(mm_start_o), 64'd0);
        checkOutput("async_rst_q_count", 64'(q_count_o), 64'd0);
        checkOutput("async_rst_cmp_valid", 64'(cmp_valid_o), 64'd0);
        checkOutput("async_rst_busy", 64'(busy_o), 64'd0);
        tick();
        rstn_i = 1'b1;
        tick();
        applyStimulus(4'd15, 64'hfeed_face_cafe_f00d, 4, 1);
        waitDrain(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #900000;
        bad++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
